// File: rtl/bcd_scan_mux4.sv
// Four-digit BCD scan controller: feeds one nibble per slot to a 7-segment decoder.
// New values are held pending and become visible only at a frame boundary.
module bcd_scan_mux4 #(
    parameter int DIV = 4,
    parameter int CW  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] value_in,
    input  logic        blank_lz,
    output logic [3:0]  bcd_out,
    output logic [3:0]  digit_en,
    output logic        blank,
    output logic        frame,
    output logic        err
);

    logic [CW-1:0] presc_r;
    logic [1:0]    idx_r;
    logic [15:0]   disp_r;
    logic [15:0]   pend_r;
    logic          pend_vld_r;
    logic          err_r;
    logic          frame_r;
    logic          slot_end_s;
    logic          boundary_s;
    logic          blank_s;

    function automatic logic nibble_bad(input logic [3:0] n);
        return (n > 4'd9);
    endfunction

    function automatic logic word_bad(input logic [15:0] w);
        return nibble_bad(w[15:12]) | nibble_bad(w[11:8]) |
               nibble_bad(w[7:4])   | nibble_bad(w[3:0]);
    endfunction

    assign slot_end_s = (presc_r == CW'(DIV - 1));
    assign boundary_s = slot_end_s && (idx_r == 2'd3);

    // Prescaler, slot index, load staging, frame pulse and sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_r    <= '0;
            idx_r      <= 2'd0;
            disp_r     <= 16'h0000;
            pend_r     <= 16'h0000;
            pend_vld_r <= 1'b0;
            err_r      <= 1'b0;
            frame_r    <= 1'b0;
        end else begin
            if (slot_end_s) begin
                presc_r <= '0;
                idx_r   <= idx_r + 2'd1;
            end else begin
                presc_r <= presc_r + CW'(1);
            end
            frame_r <= boundary_s;
            // A load coinciding with the boundary bypasses the pending stage.
            if (boundary_s) begin
                if (load) begin
                    disp_r <= value_in;
                end else if (pend_vld_r) begin
                    disp_r <= pend_r;
                end else begin
                    disp_r <= disp_r;
                end
                pend_vld_r <= 1'b0;
            end else if (load) begin
                pend_r     <= value_in;
                pend_vld_r <= 1'b1;
            end else begin
                pend_vld_r <= pend_vld_r;
            end
            if (load && word_bad(value_in)) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
        end
    end

    // Slot decode: nibble select, leading-zero blanking and digit enable.
    always_comb begin
        bcd_out  = disp_r[3:0];
        blank_s  = 1'b0;
        digit_en = 4'b0000;
        case (idx_r)
            2'd0: begin
                bcd_out = disp_r[3:0];
                blank_s = 1'b0;
            end
            2'd1: begin
                bcd_out = disp_r[7:4];
                blank_s = blank_lz && (disp_r[15:4] == 12'd0);
            end
            2'd2: begin
                bcd_out = disp_r[11:8];
                blank_s = blank_lz && (disp_r[15:8] == 8'd0);
            end
            2'd3: begin
                bcd_out = disp_r[15:12];
                blank_s = blank_lz && (disp_r[15:12] == 4'd0);
            end
            default: begin
                bcd_out = disp_r[3:0];
                blank_s = 1'b0;
            end
        endcase
        if (blank_s) begin
            digit_en = 4'b0000;
        end else begin
            digit_en = 4'b0001 << idx_r;
        end
    end

    assign blank = blank_s;
    assign frame = frame_r;
    assign err   = err_r;

endmodule

// File: tb/tb_bcd_scan_mux4.sv
// Scoreboard bench for bcd_scan_mux4: a time-based reference model pushes expected
// state every edge and a negedge monitor pops and compares the DUT outputs.
module tb_bcd_scan_mux4;

    localparam int DIV       = 4;
    localparam int FRAME_CYC = 4 * DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] value_in = 16'h0000;
    logic        blank_lz = 1'b0;
    logic [3:0]  bcd_out;
    logic [3:0]  digit_en;
    logic        blank;
    logic        frame;
    logic        err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          idx;
        logic [15:0] disp;
        logic        frame;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] pend_q[$];
    int          m_t = 0;
    logic [15:0] m_disp = 16'h0000;
    logic        m_err = 1'b0;
    logic        m_frame = 1'b0;

    bcd_scan_mux4 #(.DIV(DIV), .CW(16)) dut (
        .clk(clk), .rst(rst), .load(load), .value_in(value_in),
        .blank_lz(blank_lz), .bcd_out(bcd_out), .digit_en(digit_en),
        .blank(blank), .frame(frame), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic has_bad(input logic [15:0] v);
        for (int k = 0; k < 4; k++) begin
            if (((v >> (4 * k)) & 16'h000F) > 16'd9) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Reference model: slot position follows from cycles since reset.
    always @(posedge clk) begin
        exp_t e;
        logic bnd;
        if (rst) begin
            m_t = 0;
            m_disp = 16'h0000;
            pend_q.delete();
            m_err = 1'b0;
            m_frame = 1'b0;
        end else begin
            bnd = ((m_t % FRAME_CYC) == FRAME_CYC - 1);
            if (load && has_bad(value_in)) m_err = 1'b1;
            if (bnd) begin
                if (load) m_disp = value_in;
                else if (pend_q.size() > 0) m_disp = pend_q[$];
                pend_q.delete();
            end else if (load) begin
                pend_q.push_back(value_in);
            end
            m_frame = bnd;
            m_t++;
        end
        e.idx = (m_t / DIV) % 4;
        e.disp = m_disp;
        e.frame = m_frame;
        e.err = m_err;
        exp_q.push_back(e);
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
        end
    endtask

    // Monitor: compare DUT outputs against the oldest expected state.
    always @(negedge clk) begin
        exp_t e;
        logic [3:0] dig;
        logic       blk;
        logic [3:0] den;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            dig = 4'((e.disp >> (4 * e.idx)) & 16'h000F);
            blk = blank_lz && (e.idx != 0) && ((e.disp >> (4 * e.idx)) == 16'h0000);
            den = blk ? 4'b0000 : 4'(4'b0001 << e.idx);
            check("bcd_out", {12'h000, bcd_out}, {12'h000, dig});
            check("digit_en", {12'h000, digit_en}, {12'h000, den});
            check("blank", {15'h0000, blank}, {15'h0000, blk});
            check("frame", {15'h0000, frame}, {15'h0000, e.frame});
            check("err", {15'h0000, err}, {15'h0000, e.err});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [15:0] v);
        load = 1'b1;
        value_in = v;
        tick(1);
        load = 1'b0;
    endtask

    // Advance until the next edge samples the given frame phase.
    task automatic wait_phase(input int p);
        for (int i = 0; i < 2 * FRAME_CYC && (m_t % FRAME_CYC) != p; i++) tick(1);
    endtask

    function automatic logic [15:0] gen_value();
        logic [15:0] v;
        for (int k = 0; k < 4; k++) begin
            if ($urandom_range(0, 19) == 0) v[4 * k +: 4] = 4'($urandom_range(10, 15));
            else v[4 * k +: 4] = 4'($urandom_range(0, 9));
        end
        return v;
    endfunction

    initial begin
        // Reset and free-running scan
        tick(2);
        rst = 1'b0;
        tick(16);
        // Deferred load in slot 1, cycle 1
        wait_phase(5);
        do_load(16'h1234);
        tick(20);
        // Last load wins, then a load on the boundary edge
        wait_phase(2);
        do_load(16'h1111);
        tick(3);
        do_load(16'h2222);
        tick(16);
        wait_phase(15);
        do_load(16'h5678);
        tick(4);
        // Leading-zero blanking on and off
        do_load(16'h0042);
        blank_lz = 1'b1;
        tick(2 * FRAME_CYC);
        blank_lz = 1'b0;
        tick(FRAME_CYC);
        // Invalid BCD stays sticky until reset
        do_load(16'h0A01);
        tick(FRAME_CYC + 4);
        do_load(16'h0001);
        tick(FRAME_CYC);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(4);
        // Reset mid-scan discards display and pending contents
        do_load(16'h9876);
        tick(FRAME_CYC + 2);
        wait_phase(5);
        do_load(16'h1111);
        wait_phase(8);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(2 * FRAME_CYC);
        // Randomized traffic
        for (int c = 0; c < 800; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            load = ($urandom_range(0, 5) == 0);
            value_in = gen_value();
            if ($urandom_range(0, 19) == 0) blank_lz = ~blank_lz;
            tick(1);
        end
        rst = 1'b0;
        load = 1'b0;
        tick(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
